// File: rtl/bp_pkg.sv
// Shared types and constants for the branch history table / target buffer.
// Counter encodings and the per-entry record are used by the top and the counter sub-module.
package bp_pkg;

  localparam int BP_TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    logic [1:0]          ctr;
  } bp_entry_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one 2-bit saturating direction counter.
// force_st pins the counter to strongly-taken (unconditional jumps).
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_force_st,
  output logic [1:0] o_ctr
);

  // NOTE: o_ctr gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    o_ctr = i_ctr;
    if (i_force_st) begin
      o_ctr = ST;
    end else if (i_taken) begin
      if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BHT + BTB: combinational fetch lookup, registered resolution update,
// plus branch / mispredict performance counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = BP_TAG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  output logic             BPF,
  output logic [31:0]      PredTargetF,
  input  logic             UpdateB,
  input  logic             BranchB,
  input  logic             JumpB,
  input  logic             TakenB,
  input  logic [31:0]      PCB,
  input  logic [31:0]      TargetB,
  input  logic             MispredB,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int DEPTH = 1 << IDX_W;

  bp_entry_t        r_tbl [DEPTH];
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_idx_f, w_idx_b;
  logic [TAG_W-1:0] w_tag_f, w_tag_b;
  bp_entry_t        w_ent_f, w_ent_b;
  logic             w_hit_f, w_hit_b;
  logic             w_upd;
  logic             w_taken_any;
  logic [1:0]       w_ctr_next;

  assign w_idx_f = PCF[IDX_W+1:2];
  assign w_tag_f = PCF[TAG_W+IDX_W+1:IDX_W+2];
  assign w_idx_b = PCB[IDX_W+1:2];
  assign w_tag_b = PCB[TAG_W+IDX_W+1:IDX_W+2];

  assign w_ent_f = r_tbl[w_idx_f];
  assign w_ent_b = r_tbl[w_idx_b];

  // Lookup reads the stored state only; a same-cycle update is not forwarded.
  // Gating with reset keeps the prediction off during the reset cycle itself.
  assign w_hit_f     = w_ent_f.valid && (w_ent_f.tag == w_tag_f) && !reset;
  assign BPF         = w_hit_f && w_ent_f.ctr[1];
  assign PredTargetF = BPF ? w_ent_f.target : 32'h0;

  assign w_hit_b     = w_ent_b.valid && (w_ent_b.tag == w_tag_b);
  assign w_upd       = UpdateB && (BranchB || JumpB);
  assign w_taken_any = TakenB || JumpB;

  // JumpB wins when both type flags are set.
  bp_sat_ctr u_sat_ctr (
    .i_ctr      (w_ent_b.ctr),
    .i_taken    (TakenB),
    .i_force_st (JumpB),
    .o_ctr      (w_ctr_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only valid and ctr are reset; tag/target are plain storage and are masked by valid.
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i].valid <= 1'b0;
        r_tbl[i].ctr   <= WNT;
      end
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_upd) begin
        if (w_hit_b) begin
          r_tbl[w_idx_b].ctr <= w_ctr_next;
          if (w_taken_any) r_tbl[w_idx_b].target <= TargetB;
        end else if (w_taken_any) begin
          r_tbl[w_idx_b].valid  <= 1'b1;
          r_tbl[w_idx_b].tag    <= w_tag_b;
          r_tbl[w_idx_b].target <= TargetB;
          r_tbl[w_idx_b].ctr    <= JumpB ? ST : WT;
        end
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (UpdateB && MispredB) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign BranchCnt  = r_branch_cnt;
  assign MispredCnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: a vector table of update/lookup pairs
// with a scoreboard queue, followed by hand sequences for counters and mid-run reset.
module tb_branch_predictor_btb;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      PCF;
  logic             BPF;
  logic [31:0]      PredTargetF;
  logic             UpdateB, BranchB, JumpB, TakenB, MispredB;
  logic [31:0]      PCB, TargetB;
  logic [CNT_W-1:0] BranchCnt, MispredCnt;

  branch_predictor_btb #(.IDX_W(6), .TAG_W(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .BPF         (BPF),
    .PredTargetF (PredTargetF),
    .UpdateB     (UpdateB),
    .BranchB     (BranchB),
    .JumpB       (JumpB),
    .TakenB      (TakenB),
    .PCB         (PCB),
    .TargetB     (TargetB),
    .MispredB    (MispredB),
    .BranchCnt   (BranchCnt),
    .MispredCnt  (MispredCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd, br, jmp, tk, mis;
    logic [31:0] pcb, tgt, pcf;
    logic        exp_bpf;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    string       name;
    logic        bpf;
    logic [31:0] tgt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic upd, br, jmp, tk, mis, input logic [31:0] pcb, tgt,
                              pcf, input logic eb, input logic [31:0] et);
    vec_t v;
    v.upd = upd; v.br = br; v.jmp = jmp; v.tk = tk; v.mis = mis;
    v.pcb = pcb; v.tgt = tgt; v.pcf = pcf; v.exp_bpf = eb; v.exp_tgt = et;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, push the expected lookup, then
  // sample a little later (before the next rising edge) and pop/compare.
  task automatic drive(input string name, input vec_t v);
    exp_t e, got;
    @(negedge clk);
    UpdateB = v.upd; BranchB = v.br; JumpB = v.jmp; TakenB = v.tk; MispredB = v.mis;
    PCB = v.pcb; TargetB = v.tgt; PCF = v.pcf;
    e.name = name; e.bpf = v.exp_bpf; e.tgt = v.exp_tgt;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      check({got.name, ".bpf"}, {31'b0, BPF}, {31'b0, got.bpf});
      check({got.name, ".tgt"}, PredTargetF, got.tgt);
    end
  endtask

  task automatic idle_lookup(input string name, input logic [31:0] pcf,
                             input logic eb, input logic [31:0] et);
    drive(name, mk(0, 0, 0, 0, 0, 32'h0, 32'h0, pcf, eb, et));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_br = 0;
    int exp_mis = 0;

    reset = 1'b1; PCF = 32'h100; UpdateB = 0; BranchB = 0; JumpB = 0; TakenB = 0;
    MispredB = 0; PCB = 0; TargetB = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst.bpf", {31'b0, BPF}, 32'h0);
    check("rst.tgt", PredTargetF, 32'h0);
    check("rst.bcnt", BranchCnt, 32'h0);
    check("rst.mcnt", MispredCnt, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //                 upd br jmp tk mis   pcb        tgt        pcf        bpf tgt
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 0, 32'h000)); // cold miss
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h100, 32'h080, 32'h100, 0, 32'h000)); // no bypass
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 1, 32'h080)); // ctr 10
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h100, 32'h0f0, 32'h100, 1, 32'h080)); // ->01
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h100, 32'h0f0, 32'h100, 0, 32'h000)); // ->00
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h100, 32'h0f0, 32'h100, 0, 32'h000)); // 00 sat
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h100, 32'h0f0, 32'h100, 0, 32'h000)); // 00 sat
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h100, 32'h080, 32'h100, 0, 32'h000)); // ->01
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h100, 32'h080, 32'h100, 0, 32'h000)); // ->10
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 1, 32'h080));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h200, 0, 32'h000)); // alias miss
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h200, 32'h300, 32'h200, 0, 32'h000)); // overwrite
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 0, 32'h000)); // evicted
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h200, 1, 32'h300));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h100, 32'h080, 32'h200, 1, 32'h300)); // evict 0x200
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h200, 0, 32'h000));
    vecs.push_back(mk(1, 0, 1, 1, 0, 32'h200, 32'h400, 32'h200, 0, 32'h000)); // JAL alloc 11
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h200, 32'h0f0, 32'h200, 1, 32'h400)); // 11->10
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h200, 1, 32'h400)); // still taken
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h200, 32'h0f0, 32'h200, 1, 32'h400)); // 10->01
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h200, 0, 32'h000));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h203, 32'h500, 32'h200, 0, 32'h000)); // PC[1:0] ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h201, 1, 32'h500));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h300, 32'h600, 32'h300, 0, 32'h000)); // br+jmp = jump
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h300, 32'h0f0, 32'h300, 1, 32'h600)); // 11->10
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h300, 1, 32'h600));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h104, 32'h700, 32'h104, 0, 32'h000)); // no strobe
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h104, 32'h700, 32'h104, 0, 32'h000)); // not a branch
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h000, 32'h000, 32'h104, 0, 32'h000));

    foreach (vecs[i]) begin
      drive($sformatf("vec%0d", i), vecs[i]);
      if (vecs[i].upd && (vecs[i].br || vecs[i].jmp)) exp_br++;
      if (vecs[i].upd && vecs[i].mis) exp_mis++;
    end
    check("tbl.bcnt", BranchCnt, exp_br);
    check("tbl.mcnt", MispredCnt, exp_mis);

    // Counter sequence from a clean table.
    @(negedge clk);
    reset = 1'b1; UpdateB = 0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("cnt0.bcnt", BranchCnt, 32'd0);
    check("cnt0.mcnt", MispredCnt, 32'd0);
    for (int i = 0; i < 5; i++)
      drive($sformatf("cnt_br%0d", i),
            mk(1, 1, 0, 1, (i < 2), 32'h100, 32'h080, 32'h300, 0, 32'h000));
    drive("cnt_none", mk(1, 0, 0, 0, 0, 32'h100, 32'h999, 32'h300, 0, 32'h000));
    idle_lookup("cnt_hit", 32'h100, 1, 32'h080);
    check("cnt.bcnt", BranchCnt, 32'd5);
    check("cnt.mcnt", MispredCnt, 32'd2);

    // Reset in the middle of traffic, with an update that must be discarded.
    @(negedge clk);
    reset = 1'b1; UpdateB = 1; BranchB = 1; JumpB = 0; TakenB = 1; MispredB = 1;
    PCB = 32'h140; TargetB = 32'h900; PCF = 32'h100;
    #2;
    check("midrst.bpf", {31'b0, BPF}, 32'h0);
    check("midrst.tgt", PredTargetF, 32'h0);
    @(negedge clk);
    reset = 1'b0; UpdateB = 0; BranchB = 0; TakenB = 0; MispredB = 0;
    #2;
    check("midrst.bcnt", BranchCnt, 32'd0);
    check("midrst.mcnt", MispredCnt, 32'd0);
    idle_lookup("post_rst_100", 32'h100, 0, 32'h000);
    idle_lookup("post_rst_140", 32'h140, 0, 32'h000);
    // A single taken update after reset must start from WNT (01) -> allocate at 10.
    drive("post_rst_alloc", mk(1, 1, 0, 1, 0, 32'h140, 32'h900, 32'h140, 0, 32'h000));
    idle_lookup("post_rst_hit", 32'h140, 1, 32'h900);

    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Direct-mapped branch history table (2-bit saturating counters) plus branch target buffer for the pipelined RISC-V core with branch prediction.
- Fetch stage looks up the PC combinationally and gets a predict-taken flag and predicted target.
- Branch-resolution stage writes back the resolved outcome one per cycle.
- The prediction is carried down the pipe to the B stage and consumed by the PC-source select logic to choose redirect/recovery. The block also keeps branch and mispredict performance counters.

Parameters:
- IDX_W, 6, index width; table depth = 2**IDX_W entries.
- TAG_W, 8, stored tag width.
- CNT_W, 32, performance counter width.

Ports:
- clk  input  1  core clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- PCF  input  32  fetch-stage PC for lookup.
- BPF  output  1  predict taken for PCF.
- PredTargetF  output  32  predicted target for PCF; 0 when BPF=0.
- UpdateB  input  1  resolution-stage update strobe; at most one per cycle.
- BranchB  input  1  resolved instruction is a conditional branch (opcode 1100011).
- JumpB  input  1  resolved instruction is JAL; JALR never asserts this.
- TakenB  input  1  resolved direction.
- PCB  input  32  PC of the resolved instruction.
- TargetB  input  32  resolved target address.
- MispredB  input  1  resolution stage detected a direction or target mispredict.
- BranchCnt  output  CNT_W  count of updates with BranchB or JumpB.
- MispredCnt  output  CNT_W  count of updates with MispredB.

Behaviour:
- Address fields:
  - index = PC[IDX_W+1:2].
  - tag = PC[TAG_W+IDX_W+1:IDX_W+2].
  - PC[1:0] ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational, 0 cycles from PCF):
  - hit = valid & tag match.
  - BPF = hit & ctr[1].
  - PredTargetF = BPF ? target : 32'h0.
- Update (registered, visible to lookups from the next cycle): acts only when UpdateB=1 and (BranchB|JumpB)=1; otherwise no state change.
  - Hit, BranchB: ctr saturating +1 if TakenB, saturating -1 otherwise. 11 stays 11, 00 stays 00. If TakenB, target <= TargetB.
  - Hit, JumpB: ctr <= 11, target <= TargetB.
  - Miss, taken (TakenB or JumpB): allocate/overwrite the entry. valid=1, tag, target=TargetB; ctr = 11 for JumpB, 10 for a branch.
  - Miss, not taken: no allocation.
  - BranchB and JumpB both high: treat as JumpB.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No bypass.
- Performance counters:
  - BranchCnt increments on UpdateB & (BranchB|JumpB).
  - MispredCnt increments on UpdateB & MispredB, independent of BranchB/JumpB.
  - Both wrap at 2**CNT_W modulo, no saturation.
- Reset (synchronous, one cycle, may arrive mid-operation):
  - All valid bits cleared and all ctr set to 01 (weakly not-taken). target and tag need not reset.
  - BranchCnt = 0, MispredCnt = 0.
  - Outputs during and after the reset cycle: BPF = 0, PredTargetF = 0.
  - An UpdateB in the reset cycle is discarded.
- No stall input. Lookup is purely combinational on PCF, so fetch stalls need no handling here.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - packed struct bp_entry_t {valid, tag, target, ctr}.
  - opcode constant OP_BRANCH=7'b1100011 for the upstream decode.
- One sub-module, bp_sat_ctr: combinational next-state for a 2-bit counter (inputs ctr, taken, force_st; output next ctr).
- Table array, index/tag extraction and perf counters stay in the top.

Test Plan:
- Reset, then lookup PCF=0x100 -> BPF=0, PredTargetF=0; BranchCnt=MispredCnt=0.
- Update PCB=0x100, BranchB, TakenB, TargetB=0x80 -> next cycle PCF=0x100 gives BPF=1, PredTargetF=0x80.
- Counter walk: four not-taken updates at 0x100 (10->01->00->00) -> BPF=0. Then taken, taken -> 00->01->10, BPF=1.
- Aliasing: allocate 0x100 taken, then lookup 0x100+(4<<IDX_W) (same index, different tag) -> BPF=0. Taken update there overwrites; 0x100 now misses.
- JAL update at 0x200, TargetB=0x400, on a miss -> ctr=11; one not-taken branch update -> still BPF=1 (ctr=10).
- Counters: 5 updates with BranchB, 2 with MispredB, 1 with UpdateB but neither BranchB nor JumpB -> BranchCnt=5, MispredCnt=2. Reset asserted mid-sequence with UpdateB=1 -> counters 0, table cleared, that update dropped.
